// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch response path.
// IFETCH_SLV_RANGE_CHK_EN adds a per-entry error bit to the response entry.
package ifetch_pkg;

   localparam int          IFETCH_DW        = 32;
   localparam logic [31:0] ILLEGAL_IR       = 32'h0000_0000;
   localparam int          IFETCH_RSP_DEPTH = 2;

   typedef struct packed {
      logic [IFETCH_DW-1:0] ir;
`ifdef IFETCH_SLV_RANGE_CHK_EN
      logic                 err;
`endif
   } ifetch_rsp_t;

endpackage

// File: rtl/ifetch_if.sv
// Fetch channel between the core fetch unit (master) and the instruction responder (slave).
// Handshakes: a beat transfers on a cycle where vld and rdy are both high; vld holds until then.
interface ifetch_if_t #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req_vld;
   logic          req_rdy;
   logic [AW-1:0] req_pc;
   logic          rsp_vld;
   logic          rsp_rdy;
   logic [DW-1:0] rsp_ir;

   modport master (
      output req_vld, req_pc, rsp_rdy,
      input  req_rdy, rsp_vld, rsp_ir
   );

   modport slave (
      input  req_vld, req_pc, rsp_rdy,
      output req_rdy, rsp_vld, rsp_ir
   );
endinterface

// File: rtl/ifetch_rsp_fifo.sv
// Two-entry response buffer; push and pop in the same cycle are legal even when full.
module ifetch_rsp_fifo
   import ifetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  ifetch_rsp_t din,
   input  logic        pop,
   output logic [1:0]  cnt,
   output ifetch_rsp_t head
);

   ifetch_rsp_t mem [IFETCH_RSP_DEPTH];
   logic        wr_ptr;
   logic        rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign do_pop  = pop & (cnt != 2'd0);
   // A full buffer still takes a push when the head leaves in the same cycle.
   assign do_push = push & ((cnt != 2'd2) | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
         for (int i = 0; i < IFETCH_RSP_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         cnt <= cnt + 2'(do_push) - 2'(do_pop);
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch_sram_slv.sv
// Instruction-fetch responder: reads one word per accepted PC from a 1-cycle SRAM, returns in order.
// IFETCH_SLV_RANGE_CHK_EN: out-of-window PCs skip the SRAM and return ILLEGAL_IR.
module ifetch_sram_slv
   import ifetch_pkg::*;
#(
   parameter int            AW    = 32,
   parameter int            DW    = 32,
   parameter int            DEPTH = 1024,
   parameter logic [AW-1:0] BASE  = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   ifetch_if_t.slave                ifetch,
   output logic                     sram_ce,
   output logic [$clog2(DEPTH)-1:0] sram_addr,
   input  logic [DW-1:0]            sram_rdata
);

   localparam int IW = $clog2(DEPTH);

   logic          req_hsk;
   logic          rsp_hsk;
   logic [AW-1:0] off;
   logic [IW-1:0] word_idx;
   logic          in_range;
   logic          pend;
   logic          pend_err;
   logic [1:0]    cnt;
   logic          push;
   logic          pop;
   ifetch_rsp_t   ret;
   ifetch_rsp_t   head;
   logic          unused_off;

   assign off        = ifetch.req_pc - BASE;
   assign word_idx   = off[IW+1:2];
   assign unused_off = ^{off[1:0], off[AW-1:IW+2]};

`ifdef IFETCH_SLV_RANGE_CHK_EN
   localparam logic [AW:0] LIMIT = (AW+1)'(4 * DEPTH);
   // PCs below BASE wrap to huge offsets, so one unsigned compare covers both bounds.
   assign in_range = ({1'b0, off} < LIMIT);
`else
   assign in_range = 1'b1;
`endif

   // Credit covers buffered entries plus the read still on its way back from the SRAM.
   assign ifetch.req_rdy = (({1'b0, cnt} + {2'b00, pend}) < 3'd2);
   assign req_hsk        = ifetch.req_vld & ifetch.req_rdy;

   assign sram_ce   = req_hsk & in_range;
   assign sram_addr = sram_ce ? word_idx : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend     <= 1'b0;
         pend_err <= 1'b0;
      end else begin
         pend     <= req_hsk;
         pend_err <= req_hsk & ~in_range;
      end
   end

   always_comb begin
      ret    = '0;
      ret.ir = sram_rdata;
`ifdef IFETCH_SLV_RANGE_CHK_EN
      ret.err = pend_err;
`endif
   end

   assign ifetch.rsp_vld = (cnt != 2'd0) | pend;
   assign rsp_hsk        = ifetch.rsp_vld & ifetch.rsp_rdy;

   // Returning data skips the buffer only when it is bypassed and consumed at once.
   assign push = pend & ~((cnt == 2'd0) & rsp_hsk);
   assign pop  = rsp_hsk & (cnt != 2'd0);

   ifetch_rsp_fifo u_rsp_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (ret),
      .pop   (pop),
      .cnt   (cnt),
      .head  (head)
   );

   always_comb begin
      ifetch.rsp_ir = '0;
      if (cnt != 2'd0) begin
         ifetch.rsp_ir = head.ir;
`ifdef IFETCH_SLV_RANGE_CHK_EN
         if (head.err) ifetch.rsp_ir = ILLEGAL_IR;
`endif
      end else if (pend) begin
         ifetch.rsp_ir = ret.ir;
`ifdef IFETCH_SLV_RANGE_CHK_EN
         if (pend_err) ifetch.rsp_ir = ILLEGAL_IR;
`endif
      end
   end

endmodule

// File: doc/ifetch_sram_slv.md
# ifetch_sram_slv

Instruction-fetch responder: the slave end of the `ifetch_if_t` fetch channel driven by the core's fetch unit. It accepts fetch requests carrying a PC, reads one instruction word from a single-port synchronous instruction SRAM (1-cycle read latency), and returns it on the response channel in request order. A 2-entry response buffer with a same-cycle bypass sustains one fetch per cycle, absorbs response back-pressure, and never drops SRAM read data.

## Interface
- `AW`, 32, PC/address width
- `DW`, 32, instruction width
- `DEPTH`, 1024, SRAM depth in DW-bit words (power of two)
- `BASE`, 32'h0000_0000, byte address of SRAM word 0
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `ifetch`  `ifetch_if_t.slave`  -  `req_vld` in, `req_rdy` out, `req_pc[AW-1:0]` in, `rsp_vld` out, `rsp_rdy` in, `rsp_ir[DW-1:0]` out
- `sram_ce`  out  1  SRAM read enable
- `sram_addr`  out  $clog2(DEPTH)  SRAM word address
- `sram_rdata`  in  DW  SRAM read data, valid the cycle after `sram_ce`

## Operation
- Request handshake `req_hsk = req_vld & req_rdy`; response handshake `rsp_hsk = rsp_vld & rsp_rdy`.
- Word index = `(req_pc - BASE) >> 2`, truncated to $clog2(DEPTH) bits; `req_pc[1:0]` ignored.
- `sram_ce = req_hsk` (combinational); `sram_addr` = word index.
- `pend` flag: set on the cycle after any `req_hsk`, cleared otherwise; means returning data is on `sram_rdata` this cycle.
- Credit rule: `req_rdy = (cnt + pend) < 2`, where `cnt` = buffer occupancy (0..2). Depends only on registered state; no combinational path from `rsp_rdy` to `req_rdy`.
- Response select: `cnt != 0` -> head entry; `cnt == 0 && pend` -> bypass `sram_rdata`.
- `rsp_vld = (cnt != 0) | pend`.
- Returning data is pushed into the buffer unless it is bypassed and consumed in the same cycle (`cnt == 0 && rsp_hsk`).
- Pop on `rsp_hsk` when `cnt != 0`. Push and pop may occur in the same cycle; `cnt` is then unchanged.
- Strict in-order return; no reordering, no drops, no duplicates.

## Timing
- Reset values: `req_rdy` = 1, `rsp_vld` = 0, `rsp_ir` = 0, `sram_ce` = 0, `sram_addr` = 0, `cnt` = 0, `pend` = 0.
- Latency: `req_hsk` in cycle N -> `rsp_vld` in cycle N+1 through the bypass.
- Throughput: 1 fetch/cycle while `rsp_rdy` = 1.
- Stall: with `rsp_rdy` = 0, at most 2 requests are accepted, then `req_rdy` = 0 until a pop.
- Full: `cnt` = 2 forces `req_rdy` = 0. `cnt` = 1 with `pend` = 1 also forces `req_rdy` = 0.
- `rsp_vld` is held and `rsp_ir` is stable until `rsp_hsk`.
- `rsp_rdy` may toggle freely; `req_vld` may drop without a handshake, and no SRAM access occurs in that case.
- Reset mid-operation: buffer contents and the in-flight read are discarded, and all outputs return to their reset values.

## Configuration
- `IFETCH_SLV_RANGE_CHK_EN` defined:
  - A request with `req_pc` outside [BASE, BASE+4*DEPTH) is still accepted, but `sram_ce` stays 0.
  - Its response returns `ILLEGAL_IR` in the normal slot and order, with the same latency and credit accounting.
  - A per-entry error bit travels with `pend` and the buffer entries.
- Not defined: no range check. The address wraps modulo DEPTH, and every accepted request reads the SRAM.

## Structure
- Shared package `ifetch_pkg` holds:
  - `ILLEGAL_IR` = 32'h0000_0000
  - `IFETCH_RSP_DEPTH` = 2
  - the response-entry struct: `ir` plus the optional `err` bit
- Sub-module `ifetch_rsp_fifo`: 2-entry synchronous FIFO with push, pop, count and head outputs. Its push and pop are legal in the same cycle when full.

## Test plan
- Reset, then `req_pc` 0x0, 0x4, 0x8 back-to-back with `rsp_rdy` = 1 and SRAM words 0x13, 0x93, 0x113 -> `rsp_vld` in cycles 1, 2, 3 with `rsp_ir` in that order and `req_rdy` constantly 1.
- `rsp_rdy` = 0 with continuous requests -> exactly 2 `req_hsk`, then `req_rdy` = 0. Raising `rsp_rdy` drains both in order, and `req_rdy` reasserts the cycle after the first pop.
- `rsp_rdy` toggling 1/0 every cycle during 8 sequential fetches -> all 8 words returned in order, none lost or repeated.
- `req_pc` = 0x6 -> `sram_addr` = 1. `req_pc` = 0x1000 with DEPTH = 1024:
  - macro off: wraps to `sram_addr` 0
  - macro on: `sram_ce` = 0 and `rsp_ir` = 0x0
- `rst_n` asserted while `cnt` = 2 and `pend` = 1 -> on release, `rsp_vld` = 0 and `req_rdy` = 1. The next request returns only its own data.
- Simultaneous push and pop at `cnt` = 1 -> `cnt` stays 1, and the head advances to the next word.
